bus_arb4_16b: RTL and testbench
===============================

# bus_arb4_16b

Round-robin arbiter and sequencer that shares one 16-bit datapath among four requesters. It owns the select lines of a 4:1 16-bit mux, grants the path to one requester at a time, and caps each grant at a bounded burst length. It registers the selected word onto a single downstream bus and honours a downstream stall. It sits in front of any shared single-port consumer, e.g. the memory write port contended by the fetch, load/store, DMA and debug paths.

## Interface
- `MAX_BURST`, default 4: maximum transfers per grant; legal range 1–15.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  4: request from requester i; may rise or fall in any cycle.
- `data0`..`data3`  in  16 each: payload of requester i; sampled only in a transfer cycle.
- `stall`  in  1: downstream not ready; no transfer in any cycle where it is high.
- `gnt`  out  4: registered; one-hot or all-zero.
- `sel`  out  2: registered mux select; equals the index of the set `gnt` bit, else holds its last value.
- `out_valid`  out  1: registered; high for exactly one cycle per transfer.
- `out_data`  out  16: registered word of the last transfer; holds between transfers.

## Operation
- Transfer: cycle where `gnt[i] & req[i] & ~stall`. The mux output selected by `sel` is captured into `out_data`, and `out_valid` = 1 on the next edge.
- Round-robin pointer `ptr` (2b): search order is ptr, ptr+1, ptr+2, ptr+3 mod 4. The first asserted `req` wins.
- States:
  - IDLE: `gnt` = 0.
    - If any `req` is high, grant the search winner → GRANT, `cnt` = 0.
  - GRANT, owner k:
    - Each transfer increments `cnt`.
    - Release when `req[k]` = 0, evaluated regardless of `stall`.
    - Also release on the transfer that makes `cnt` = MAX_BURST (forced rotate).
    - On release, `ptr` = k+1. Re-search on the same edge using the current `req`, with `req[k]` included only for a forced release. k may be re-granted if it is the sole requester.
    - On release with a winner: `gnt` moves directly to the winner, no idle bubble, `cnt` = 0.
    - On release with no winner → IDLE.
- `stall` freezes `cnt`, `gnt` and `sel`. It never causes a release on its own.
- `cnt` width is 4 bits; it never exceeds MAX_BURST.
- Reset mid-burst abandons the grant. An in-flight transfer sampled in the reset cycle does not produce `out_valid`.

## Timing
- Reset values: `gnt` = 0, `sel` = 0, `out_valid` = 0, `out_data` = 0; internally `ptr` = 0, `cnt` = 0, state IDLE.
- Request to grant: `req` high in cycle n (IDLE) → `gnt` in cycle n+1. The first transfer can occur in n+1.
- Transfer to output: transfer in cycle t → `out_valid`/`out_data` in cycle t+1.
- Owner handover: last transfer or `req` drop in cycle t → new `gnt` in t+1. With continuous requesters, throughput is one word per cycle.
- Simultaneous requests from IDLE: the lowest index at or after `ptr` wins.
- A requester dropping `req` in the same cycle it is granted causes zero transfers and a release on the next edge.

## Structure
- Shared package/include file holds:
  - state encodings IDLE = 1'b0, GRANT = 1'b1;
  - requester count 4;
  - data width 16.
- One sub-module: an instance of `mux4_1_16b` with `sel` driven from the `sel` register and inputs `data0`..`data3`.
- Arbitration logic, pointer, counter and output registers live in `bus_arb4_16b`. Use a rotate-priority encoder as a function, not a separate module.

## Test plan
- Reset, then `req` = 4'b0100 held, `data2` = 16'hA5A5, MAX_BURST = 4 → `gnt` = 0100 one cycle later, `sel` = 2. `out_valid` pulses 4 cycles with A5A5, then a forced re-grant of 2 (sole requester); `ptr` = 3.
- `req` = 4'b1111, each `dataI` = 16'h000I, no stall → grant order 0,1,2,3,0. Each owner gets 4 consecutive words, with no idle cycle between owners.
- Owner 1 granted, `stall` = 1 for 3 cycles → `gnt`, `sel` and `cnt` frozen, `out_valid` = 0. After `stall` drops, transfers resume and still total 4.
- Owner 0 drops `req` after 2 transfers while `req[3]` = 1 → `gnt` = 1000 on the next edge; owner 3 wins over 1 and 2 per `ptr` = 1 search order (1, 2 idle).
- `rst` asserted during a burst with a transfer in that cycle → next cycle all outputs at reset values and `out_valid` = 0.
- MAX_BURST = 1, `req` = 4'b0011 → grant alternates 0,1,0,1 each cycle, with one word per cycle.

Source files
------------

// File: rtl/bus_arb4_16b_pkg.sv
// Shared constants, state encodings and the rotate-priority search used by the arbiter.
package bus_arb4_16b_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 16;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_GRANT = 1'b1;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // First asserted request at or after ptr, wrapping modulo 4.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input logic [1:0] ptr);
        pick_t      p;
        logic [1:0] idx;
        p = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + 2'(i);
            if (!p.found && req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    function automatic logic [NUM_REQ-1:0] idx2oh(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_arb4_16b_mux.sv
// 4:1 16-bit datapath mux steered by the arbiter's registered select.
module mux4_1_16b (
    input  logic [1:0]  sel_i,
    input  logic [15:0] d0_i,
    input  logic [15:0] d1_i,
    input  logic [15:0] d2_i,
    input  logic [15:0] d3_i,
    output logic [15:0] y_o
);

    always_comb begin
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end

endmodule

// File: rtl/bus_arb4_16b.sv
// Round-robin arbiter for four requesters sharing one 16-bit path, with burst cap
// and downstream stall; the selected word is registered onto out_data_o.
module bus_arb4_16b
    import bus_arb4_16b_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [DATA_W-1:0]    data0_i,
    input  logic [DATA_W-1:0]    data1_i,
    input  logic [DATA_W-1:0]    data2_i,
    input  logic [DATA_W-1:0]    data3_i,
    input  logic                 stall_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [1:0]           sel_o,
    output logic                 out_valid_o,
    output logic [DATA_W-1:0]    out_data_o
);

    localparam logic [3:0] CNT_MAX = 4'(MAX_BURST);

    logic                state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [1:0]          sel_q, sel_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [DATA_W-1:0]   mux_y;

    logic                in_grant, xfer, forced, drop;
    logic [3:0]          cnt_inc;
    logic [1:0]          ptr_next;
    logic [NUM_REQ-1:0]  rel_req;
    pick_t               pick_idle, pick_rel;

    mux4_1_16b u_mux (
        .sel_i (sel_q),
        .d0_i  (data0_i),
        .d1_i  (data1_i),
        .d2_i  (data2_i),
        .d3_i  (data3_i),
        .y_o   (mux_y)
    );

    // While granted, sel_q always names the owner.
    assign in_grant = (state_q == STATE_GRANT);
    assign xfer     = in_grant && req_i[sel_q] && !stall_i;
    assign cnt_inc  = cnt_q + 4'd1;
    assign forced   = xfer && (cnt_inc == CNT_MAX);
    assign drop     = in_grant && !req_i[sel_q];
    assign ptr_next = sel_q + 2'd1;

    // A voluntary drop excludes the owner from the re-search; a forced rotate keeps it.
    assign rel_req   = forced ? req_i : (req_i & ~idx2oh(sel_q));
    assign pick_idle = rr_pick(req_i, ptr_q);
    assign pick_rel  = rr_pick(rel_req, ptr_next);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (!in_grant) begin
            if (pick_idle.found) begin
                state_d = STATE_GRANT;
                gnt_d   = idx2oh(pick_idle.idx);
                sel_d   = pick_idle.idx;
                cnt_d   = 4'd0;
            end
        end else if (forced || drop) begin
            ptr_d = ptr_next;
            cnt_d = 4'd0;
            if (pick_rel.found) begin
                gnt_d = idx2oh(pick_rel.idx);
                sel_d = pick_rel.idx;
            end else begin
                state_d = STATE_IDLE;
                gnt_d   = '0;
            end
        end else if (xfer) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= STATE_IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= xfer;
            if (xfer) out_data_q <= mux_y;
        end
    end

    assign gnt_o       = gnt_q;
    assign sel_o       = sel_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_bus_arb4_16b.sv
// Directed bench: stimulus pushes expected words into per-DUT queues, negedge monitors pop and compare.
module tb_bus_arb4_16b;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req, req_b;
    logic [15:0] d0, d1, d2, d3;
    logic [15:0] db0, db1, db_z;
    logic        stall;
    logic [3:0]  gnt, gnt_b;
    logic [1:0]  sel, sel_b;
    logic        ov, ov_b;
    logic [15:0] od, od_b;

    int checks = 0;
    int errors = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    bus_arb4_16b #(.MAX_BURST(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .data0_i(d0), .data1_i(d1), .data2_i(d2), .data3_i(d3),
        .stall_i(stall), .gnt_o(gnt), .sel_o(sel),
        .out_valid_o(ov), .out_data_o(od)
    );

    bus_arb4_16b #(.MAX_BURST(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b),
        .data0_i(db0), .data1_i(db1), .data2_i(db_z), .data3_i(db_z),
        .stall_i(1'b0), .gnt_o(gnt_b), .sel_o(sel_b),
        .out_valid_o(ov_b), .out_data_o(od_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ov === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid: got data %h expected no transfer", od);
            end else begin
                check("a_out_data", 32'(od), 32'(qa.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (ov_b === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_valid: got data %h expected no transfer", od_b);
            end else begin
                check("b_out_data", 32'(od_b), 32'(qb.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; req_b = '0; stall = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        db0 = 16'hB000; db1 = 16'hB001; db_z = '0;
        tick(); tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_valid", 32'(ov), 0);
        check("rst_data", 32'(od), 0);
        check("rst_ptr", 32'(dut_a.ptr_q), 0);

        // sole requester 2: four words, forced rotate re-grants 2
        rst = 1'b0; req = 4'b0100; d2 = 16'hA5A5;
        tick();
        check("t1_gnt", 32'(gnt), 'b0100);
        check("t1_sel", 32'(sel), 2);
        repeat (4) begin
            qa.push_back(16'hA5A5);
            tick();
        end
        check("t1_regrant", 32'(gnt), 'b0100);
        check("t1_ptr", 32'(dut_a.ptr_q), 3);
        check("t1_cnt", 32'(dut_a.cnt_q), 0);
        req = '0;
        tick();
        check("t1_idle", 32'(gnt), 0);

        // all four requesting: 4 words each, order 0,1,2,3,0
        do_reset();
        req = 4'b1111; d0 = 16'h0000; d1 = 16'h0001; d2 = 16'h0002; d3 = 16'h0003;
        tick();
        for (int c = 0; c < 20; c++) begin
            check("t2_gnt", 32'(gnt), 1 << ((c / 4) % 4));
            qa.push_back(16'((c / 4) % 4));
            tick();
        end
        req = '0;
        tick();

        // owner 1 stalled for 3 cycles mid-burst
        do_reset();
        req = 4'b0010; d1 = 16'h1101;
        tick();
        check("t3_gnt", 32'(gnt), 'b0010);
        qa.push_back(16'h1101);
        tick();
        stall = 1'b1; d1 = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_gnt", 32'(gnt), 'b0010);
            check("t3_stall_sel", 32'(sel), 1);
            check("t3_stall_cnt", 32'(dut_a.cnt_q), 1);
            if (i > 0) check("t3_stall_valid", 32'(ov), 0);
            tick();
        end
        stall = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            d1 = 16'h1100 + 16'(k);
            check("t3_cnt", 32'(dut_a.cnt_q), k - 1);
            qa.push_back(16'h1100 + 16'(k));
            tick();
        end
        check("t3_regrant", 32'(gnt), 'b0010);
        check("t3_cnt0", 32'(dut_a.cnt_q), 0);
        check("t3_ptr", 32'(dut_a.ptr_q), 2);
        req = '0;
        tick();

        // owner 0 drops after 2 words; 3 wins from ptr=1
        do_reset();
        req = 4'b1001; d0 = 16'h0A0A; d3 = 16'h3333;
        tick();
        check("t4_gnt0", 32'(gnt), 'b0001);
        repeat (2) begin
            qa.push_back(16'h0A0A);
            tick();
        end
        req = 4'b1000;
        tick();
        check("t4_gnt3", 32'(gnt), 'b1000);
        check("t4_sel3", 32'(sel), 3);
        check("t4_ptr", 32'(dut_a.ptr_q), 1);
        qa.push_back(16'h3333);
        tick();
        req = '0;
        tick();

        // reset lands on a transfer cycle
        do_reset();
        req = 4'b0100; d2 = 16'h5555;
        tick();
        qa.push_back(16'h5555);
        tick();
        rst = 1'b1;
        tick();
        check("t5_gnt", 32'(gnt), 0);
        check("t5_sel", 32'(sel), 0);
        check("t5_valid", 32'(ov), 0);
        check("t5_data", 32'(od), 0);
        check("t5_cnt", 32'(dut_a.cnt_q), 0);
        rst = 1'b0; req = '0;
        tick();

        // MAX_BURST=1: 0 and 1 alternate every cycle
        req_b = 4'b0011;
        tick();
        for (int c = 0; c < 6; c++) begin
            check("t6_gnt", 32'(gnt_b), (c % 2 == 1) ? 'b0010 : 'b0001);
            qb.push_back((c % 2 == 1) ? 16'hB001 : 16'hB000);
            tick();
        end
        req_b = '0;
        tick();

        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) tick();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d words outstanding expected 0/0", qa.size(), qb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
